// File: rtl/mat_uart_printer_pkg.sv
// Shared constants for the matrix text printer: ASCII codes, line layout and FSM states.
package mat_uart_printer_pkg;

    localparam logic [7:0] LBRACK  = 8'h5B;
    localparam logic [7:0] RBRACK  = 8'h5D;
    localparam logic [7:0] COMMA   = 8'h2C;
    localparam logic [7:0] SPACE   = 8'h20;
    localparam logic [7:0] CR      = 8'h0D;
    localparam logic [7:0] LF      = 8'h0A;
    localparam logic [7:0] ZERO    = 8'h30;
    localparam logic [7:0] A_UPPER = 8'h41;

    localparam logic [4:0] LINE_LEN = 5'd25;
    localparam logic [4:0] LAST_POS = LINE_LEN - 5'd1;
    localparam logic [4:0] DIG0_POS = 5'd2;
    localparam logic [4:0] DIG1_POS = 5'd9;
    localparam logic [4:0] DIG2_POS = 5'd16;

    typedef enum logic [1:0] {
        StIdle,
        StEmit,
        StFinish
    } state_e;

endpackage

// File: rtl/mat_uart_printer_hex_to_ascii.sv
// Converts one hex nibble to its uppercase ASCII character.
module mat_uart_printer_hex_to_ascii
    import mat_uart_printer_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [7:0] o_char
);

    always_comb begin
        if (i_nibble < 4'd10) begin
            o_char = ZERO + {4'h0, i_nibble};
        end else begin
            o_char = A_UPPER + {4'h0, i_nibble} - 8'd10;
        end
    end

endmodule

// File: rtl/mat_uart_printer.sv
// Captures a packed 3x3 result matrix and streams it as hex text lines over a
// valid/ready byte interface.
module mat_uart_printer
    import mat_uart_printer_pkg::*;
#(
    parameter int unsigned ELEM_W = 17,
    parameter int unsigned N      = 3
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_start,
    input  logic [0:N*N*ELEM_W-1]   i_c_mat,
    output logic [7:0]              o_tx_data,
    output logic                    o_tx_valid,
    input  logic                    i_tx_ready,
    output logic                    o_busy,
    output logic                    o_done
);

    localparam int unsigned HEX_DIGITS = (ELEM_W + 3) / 4;

    if (N != 3) begin : g_bad_n
        $error("mat_uart_printer supports only N == 3");
    end

    state_e                  r_state;
    logic [0:N*N*ELEM_W-1]   r_data;
    logic [1:0]              r_row;
    logic [4:0]              r_pos;
    logic [7:0]              r_tx_data;
    logic                    r_tx_valid;
    logic                    r_busy;
    logic                    r_done;

    logic [1:0]              w_nrow;
    logic [4:0]              w_npos;
    logic [1:0]              w_col;
    logic [4:0]              w_dig;
    int unsigned             w_nib;
    logic [ELEM_W-1:0]       w_elem;
    logic [HEX_DIGITS*4-1:0] w_ext;
    logic [3:0]              w_nibble;
    logic [7:0]              w_hex_char;
    logic [7:0]              w_char;
    logic                    w_xfer;
    logic                    w_last;

    assign w_xfer = r_tx_valid && i_tx_ready;
    assign w_last = (r_row == 2'd2) && (r_pos == LAST_POS);

    // Position of the byte that follows the one currently on the bus.
    always_comb begin
        if (r_pos == LAST_POS) begin
            w_npos = 5'd0;
            w_nrow = r_row + 2'd1;
        end else begin
            w_npos = r_pos + 5'd1;
            w_nrow = r_row;
        end
    end

    always_comb begin
        w_col = 2'd0;
        w_dig = 5'd0;
        if (w_npos >= DIG2_POS) begin
            w_col = 2'd2;
            w_dig = w_npos - DIG2_POS;
        end else if (w_npos >= DIG1_POS) begin
            w_col = 2'd1;
            w_dig = w_npos - DIG1_POS;
        end else if (w_npos >= DIG0_POS) begin
            w_dig = w_npos - DIG0_POS;
        end
    end

    always_comb begin
        w_nib = 0;
        if (32'(w_dig) < HEX_DIGITS) begin
            w_nib = HEX_DIGITS - 1 - 32'(w_dig);
        end
    end

    assign w_elem = r_data[(32'(w_nrow) * N + 32'(w_col)) * ELEM_W +: ELEM_W];

    // Zero-extend to whole nibbles so the top digit never picks up stray bits.
    always_comb begin
        w_ext = '0;
        w_ext[ELEM_W-1:0] = w_elem;
    end

    assign w_nibble = w_ext[w_nib*4 +: 4];

    mat_uart_printer_hex_to_ascii u_hex (
        .i_nibble (w_nibble),
        .o_char   (w_hex_char)
    );

    always_comb begin
        case (w_npos)
            5'd0:                      w_char = LBRACK;
            5'd1, 5'd8, 5'd15, 5'd21:  w_char = SPACE;
            5'd7, 5'd14:               w_char = COMMA;
            5'd22:                     w_char = RBRACK;
            5'd23:                     w_char = CR;
            5'd24:                     w_char = LF;
            default:                   w_char = w_hex_char;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_data     <= '0;
            r_row      <= 2'd0;
            r_pos      <= 5'd0;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_data     <= i_c_mat;
                        r_row      <= 2'd0;
                        r_pos      <= 5'd0;
                        r_tx_data  <= LBRACK;
                        r_tx_valid <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= StEmit;
                    end
                end
                StEmit: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            r_tx_valid <= 1'b0;
                            r_tx_data  <= 8'h00;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_state    <= StFinish;
                        end else begin
                            r_row     <= w_nrow;
                            r_pos     <= w_npos;
                            r_tx_data <= w_char;
                        end
                    end
                end
                StFinish: begin
                    r_done  <= 1'b0;
                    r_row   <= 2'd0;
                    r_pos   <= 5'd0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_tx_data  = r_tx_data;
    assign o_tx_valid = r_tx_valid;
    assign o_busy     = r_busy;
    assign o_done     = r_done;

endmodule

// File: tb/tb_mat_uart_printer.sv
// Scoreboard bench for mat_uart_printer: expected text is queued by the stimulus,
// a negedge monitor pops and compares every accepted byte.
module tb_mat_uart_printer;

    typedef struct {
        logic [7:0] ch;
        bit         last;
    } exp_t;

    logic            clk;
    logic            rst;
    logic            start;
    logic [0:9*17-1] c_mat;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready;
    logic            busy;
    logic            done;

    int   checks;
    int   failures;
    exp_t q[$];
    int   n_xfer;
    int   done_cnt;

    mat_uart_printer dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_start    (start),
        .i_c_mat    (c_mat),
        .o_tx_data  (tx_data),
        .o_tx_valid (tx_valid),
        .i_tx_ready (tx_ready),
        .o_busy     (busy),
        .o_done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Monitor: pops one expected byte per accepted transfer.
    logic       stalled;
    logic [7:0] stall_data;
    bit         prev_final;
    always @(negedge clk) begin
        exp_t e;
        bit   fin;
        fin = 1'b0;
        if (rst) begin
            stalled    = 1'b0;
            prev_final = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid", {31'd0, tx_valid}, 32'd1);
                check("stall_data", {24'd0, tx_data}, {24'd0, stall_data});
            end
            if (done) begin
                done_cnt++;
                check("done_timing", {31'd0, prev_final}, 32'd1);
            end
            if (tx_valid && tx_ready) begin
                n_xfer++;
                if (q.size() == 0) begin
                    check("unexpected_byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    check("byte", {24'd0, tx_data}, {24'd0, e.ch});
                    fin = e.last;
                end
            end
            stalled    = tx_valid && !tx_ready;
            stall_data = tx_data;
            prev_final = fin;
        end
    end

    task automatic push_lines(input string l0, input string l1, input string l2);
        string l[3];
        exp_t  e;
        l[0] = l0;
        l[1] = l1;
        l[2] = l2;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < l[r].len(); i++) begin
                e.ch   = l[r][i];
                e.last = (r == 2) && (i == l[r].len() - 1);
                q.push_back(e);
            end
        end
    endtask

    task automatic set_mat(input logic [16:0] a, input logic [16:0] b, input logic [16:0] c,
                           input logic [16:0] d, input logic [16:0] e, input logic [16:0] f,
                           input logic [16:0] g, input logic [16:0] h, input logic [16:0] i);
        logic [16:0] v[9];
        v = '{a, b, c, d, e, f, g, h, i};
        for (int k = 0; k < 9; k++) c_mat[k*17 +: 17] = v[k];
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // mode 0: always ready; mode 1: ready one cycle in three.
    task automatic run_until_done(input int mode, output int cycles);
        cycles = -1;
        for (int k = 1; k <= 600; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                cycles = k;
                break;
            end
            tx_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
        end
        tx_ready = 1'b1;
        check("done_seen", {31'd0, cycles > 0}, 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    localparam string ID0 = "[ 00001, 00000, 00000 ]\r\n";
    localparam string ID1 = "[ 00000, 00001, 00000 ]\r\n";
    localparam string ID2 = "[ 00000, 00000, 00001 ]\r\n";
    localparam string MX  = "[ 1FFFF, 1FFFF, 1FFFF ]\r\n";
    localparam string BP0 = "[ 00010, 00020, 00030 ]\r\n";
    localparam string BP1 = "[ 00040, 00050, 00060 ]\r\n";
    localparam string BP2 = "[ 00070, 00080, 00090 ]\r\n";
    localparam string LT0 = "[ 0ABCD, 12345, 1E0F9 ]\r\n";
    localparam string LT1 = "[ 00000, 1FFFF, 0BEEF ]\r\n";
    localparam string LT2 = "[ 10000, 0C0DE, 00F0F ]\r\n";

    task automatic set_identity();
        set_mat(17'd1, 17'd0, 17'd0, 17'd0, 17'd1, 17'd0, 17'd0, 17'd0, 17'd1);
    endtask

    task automatic set_letters();
        set_mat(17'h0ABCD, 17'h12345, 17'h1E0F9, 17'h00000, 17'h1FFFF, 17'h0BEEF,
                17'h10000, 17'h0C0DE, 17'h00F0F);
    endtask

    initial begin
        int cyc;
        int base_x;
        int base_d;
        checks   = 0;
        failures = 0;
        n_xfer   = 0;
        done_cnt = 0;
        rst      = 1'b1;
        start    = 1'b0;
        tx_ready = 1'b1;
        c_mat    = '0;
        idle_cycles(3);
        check("rst_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_data", {24'd0, tx_data}, 32'h00);
        rst = 1'b0;
        idle_cycles(2);

        // Identity, always ready: 75 bytes back to back, done one cycle after last.
        set_identity();
        push_lines(ID0, ID1, ID2);
        base_x = n_xfer;
        base_d = done_cnt;
        pulse_start();
        check("cap_busy", {31'd0, busy}, 32'd1);
        check("cap_valid", {31'd0, tx_valid}, 32'd1);
        check("cap_first", {24'd0, tx_data}, 32'h5B);
        run_until_done(0, cyc);
        check("id_cycles", cyc, 75);
        check("id_busy_end", {31'd0, busy}, 32'd0);
        check("id_valid_end", {31'd0, tx_valid}, 32'd0);
        idle_cycles(3);
        check("id_bytes", n_xfer - base_x, 75);
        check("id_done_cnt", done_cnt - base_d, 1);
        check("id_queue", q.size(), 0);

        // All-max values.
        set_mat(17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF,
                17'h1FFFF, 17'h1FFFF, 17'h1FFFF);
        push_lines(MX, MX, MX);
        base_x = n_xfer;
        pulse_start();
        run_until_done(0, cyc);
        check("max_cycles", cyc, 75);
        idle_cycles(2);
        check("max_bytes", n_xfer - base_x, 75);
        check("max_queue", q.size(), 0);

        // Backpressure, ready one cycle in three.
        set_mat(17'h10, 17'h20, 17'h30, 17'h40, 17'h50, 17'h60, 17'h70, 17'h80, 17'h90);
        push_lines(BP0, BP1, BP2);
        base_x = n_xfer;
        pulse_start();
        run_until_done(1, cyc);
        idle_cycles(2);
        check("bp_bytes", n_xfer - base_x, 75);
        check("bp_queue", q.size(), 0);

        // Start pulse with new data mid-print must be ignored.
        set_letters();
        push_lines(LT0, LT1, LT2);
        base_d = done_cnt;
        pulse_start();
        idle_cycles(20);
        set_identity();
        start = 1'b1;
        idle_cycles(1);
        start = 1'b0;
        check("swb_busy", {31'd0, busy}, 32'd1);
        run_until_done(0, cyc);
        idle_cycles(5);
        check("swb_idle", {31'd0, tx_valid}, 32'd0);
        check("swb_done_cnt", done_cnt - base_d, 1);
        check("swb_queue", q.size(), 0);

        // Held start: second print begins the cycle after IDLE is re-entered.
        set_identity();
        push_lines(ID0, ID1, ID2);
        base_x = n_xfer;
        base_d = done_cnt;
        @(posedge clk);
        #1 start = 1'b1;
        run_until_done(0, cyc);
        set_letters();
        push_lines(LT0, LT1, LT2);
        idle_cycles(1);
        check("held_idle_valid", {31'd0, tx_valid}, 32'd0);
        check("held_idle_busy", {31'd0, busy}, 32'd0);
        idle_cycles(1);
        check("held_recap_valid", {31'd0, tx_valid}, 32'd1);
        check("held_recap_busy", {31'd0, busy}, 32'd1);
        start = 1'b0;
        run_until_done(0, cyc);
        check("held_cycles", cyc, 75);
        idle_cycles(3);
        check("held_bytes", n_xfer - base_x, 150);
        check("held_done_cnt", done_cnt - base_d, 2);
        check("held_queue", q.size(), 0);

        // Asynchronous reset after 10 transfers, then a clean restart.
        set_letters();
        push_lines(LT0, LT1, LT2);
        base_x = n_xfer;
        pulse_start();
        for (int k = 0; k < 100; k++) begin
            if (n_xfer - base_x >= 10) break;
            @(posedge clk);
            #1;
        end
        check("rm_ten", n_xfer - base_x, 10);
        rst = 1'b1;
        q.delete();
        #1;
        check("rm_valid", {31'd0, tx_valid}, 32'd0);
        check("rm_busy", {31'd0, busy}, 32'd0);
        check("rm_done", {31'd0, done}, 32'd0);
        idle_cycles(2);
        rst = 1'b0;
        idle_cycles(1);
        set_identity();
        push_lines(ID0, ID1, ID2);
        base_x = n_xfer;
        pulse_start();
        check("rm_first", {24'd0, tx_data}, 32'h5B);
        run_until_done(0, cyc);
        idle_cycles(2);
        check("rm_bytes", n_xfer - base_x, 75);
        check("rm_queue", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
